// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   - state_e    : scanner FSM states
//   - ColStart   : column drive pattern after reset (column 0 driven low)
//   - KeyCodeW   : width of the row*4+col key code
//   - col_index  : one-hot-low column drive -> column number
//   - lowest_low : index of the lowest active-low row
package keypad_pkg;

    localparam int unsigned KeyCodeW = 4;
    localparam logic [3:0]  ColStart = 4'b1110;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld,
        StRelease
    } state_e;

    function automatic logic [1:0] col_index(input logic [3:0] col_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Scans downward so the lowest low row is the one left in idx.
    function automatic logic [1:0] lowest_low(input logic [3:0] row_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan tick divider: free-running counter 0..SCAN_DIV-1; tick is high for the
// one clk in which the counter sits at SCAN_DIV-1.
//   clk  : system clock
//   rst  : asynchronous active-high reset (counter cleared)
//   tick : one-clk strobe every SCAN_DIV clocks
module keypad_tick_gen #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [15:0] CntMax = 16'(SCAN_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (tick) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounced press/release.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   row_in    : keypad rows, active-low, asynchronous to clk
//   col_out   : column drive, active-low one-hot
//   key_valid : one-clk pulse when a debounced press is accepted
//   key_code  : last accepted key, row*4+col
//   key_held  : high while the accepted key is considered pressed
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam logic [7:0] DebMax = 8'(DEBOUNCE_TICKS);

    logic tick;

    keypad_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    logic [3:0]          row_meta_q, row_sync_q;
    state_e              state_q, state_d;
    logic [3:0]          col_q, col_d;
    logic [1:0]          cap_row_q, cap_row_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [KeyCodeW-1:0] key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;

    logic       cap_low;
    logic [7:0] cnt_inc;
    logic [3:0] col_next;

    assign cap_low  = ~row_sync_q[cap_row_q];
    assign cnt_inc  = cnt_q + 8'd1;
    // Rotate left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
    assign col_next = {col_q[2:0], col_q[3]};

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cap_row_d   = cap_row_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                StScan: begin
                    if (&row_sync_q) begin
                        col_d = col_next;
                    end else begin
                        cap_row_d = lowest_low(row_sync_q);
                        cnt_d     = '0;
                        state_d   = StDebounce;
                    end
                end
                StDebounce: begin
                    if (cap_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebMax) begin
                            state_d     = StHeld;
                            key_code_d  = {cap_row_q, col_index(col_q)};
                            key_valid_d = 1'b1;
                        end
                    end else begin
                        state_d = StScan;
                        col_d   = col_next;
                    end
                end
                StHeld: begin
                    if (!cap_low) begin
                        cnt_d   = '0;
                        state_d = StRelease;
                    end
                end
                StRelease: begin
                    if (!cap_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DebMax) begin
                            state_d = StScan;
                            col_d   = col_next;
                        end
                    end else begin
                        // Bounce back low: key still down, no new event.
                        state_d = StHeld;
                    end
                end
                default: state_d = StScan;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q  <= 4'b1111;
            row_sync_q  <= 4'b1111;
            state_q     <= StScan;
            col_q       <= ColStart;
            cap_row_q   <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            row_meta_q  <= row_in;
            row_sync_q  <= row_meta_q;
            state_q     <= state_d;
            col_q       <= col_d;
            cap_row_q   <= cap_row_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col_out   = col_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = (state_q == StHeld) || (state_q == StRelease);

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_TICKS=3).
// A 16-bit "pressed" matrix models the physical keys; rows are derived from
// it and the driven column. A per-tick reference model tracks expected state.
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic       clk;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    logic [15:0] pressed;

    int n_cmp;
    int n_fail;

    // Reference model state (key_valid is what should be visible after a tick).
    int m_col, m_mode, m_row, m_cnt, m_code;
    bit m_valid, m_held;

    bit         off_valid, off_moved;
    logic [11:0] obs;

    keypad_scan #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_TICKS(DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_held (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical matrix: a row reads low if any pressed key sits on a driven column.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic model_reset();
        m_col = 0; m_mode = 0; m_row = 0; m_cnt = 0; m_code = 0;
        m_valid = 0; m_held = 0;
    endtask

    // One scan tick of the key-scanning rules. Modes: 0 scanning, 1 confirming
    // a press, 2 key down, 3 confirming a release.
    task automatic model_tick();
        bit low [4];
        bit any;
        int first;
        any = 0; first = -1;
        for (int r = 0; r < 4; r++) begin
            low[r] = pressed[r*4+m_col];
            if (low[r] && first < 0) first = r;
            any |= low[r];
        end
        m_valid = 0;
        case (m_mode)
            0: if (!any) m_col = (m_col + 1) % 4;
               else begin m_row = first; m_cnt = 0; m_mode = 1; end
            1: if (low[m_row]) begin
                   m_cnt++;
                   if (m_cnt == DEB) begin
                       m_mode = 2; m_code = m_row * 4 + m_col; m_valid = 1;
                   end
               end else begin
                   m_mode = 0; m_col = (m_col + 1) % 4;
               end
            2: if (!low[m_row]) begin m_cnt = 0; m_mode = 3; end
            default: if (!low[m_row]) begin
                         m_cnt++;
                         if (m_cnt == DEB) begin m_mode = 0; m_col = (m_col + 1) % 4; end
                     end else m_mode = 2;
        endcase
        m_held = (m_mode == 2) || (m_mode == 3);
    endtask

    function automatic logic [11:0] exp_vec();
        logic [3:0] c;
        c = 4'b1111;
        c[m_col] = 1'b0;
        return {c, m_valid, 4'(m_code), m_held, 2'b00};
    endfunction

    // Advance one full tick period; records any key_valid or column change
    // seen on the non-tick edges, then steps the model.
    task automatic tick_step();
        logic [3:0] col0;
        col0 = col_out;
        off_valid = 1'b0;
        off_moved = 1'b0;
        for (int e = 1; e <= SCAN_DIV; e++) begin
            @(posedge clk);
            #1;
            if (e < SCAN_DIV) begin
                if (key_valid) off_valid = 1'b1;
                if (col_out !== col0) off_moved = 1'b1;
            end
        end
        model_tick();
    endtask

    // Tick with no keys until the model is scanning the given column.
    task automatic seek_col(input int target);
        pressed = '0;
        for (int i = 0; i < 12 && !(m_mode == 0 && m_col == target); i++) tick_step();
    endtask

    task automatic test_reset();
        pressed = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({col_out, key_valid, key_code, key_held} !== {4'b1110, 1'b0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got col=%b v=%b code=%h held=%b want 1110/0/0/0",
                     col_out, key_valid, key_code, key_held);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_idle_scan();
        int pulses;
        pulses = 0;
        pressed = '0;
        for (int i = 0; i < 20; i++) begin
            tick_step();
            if (key_valid) pulses++;
            obs = {col_out, key_valid, key_code, key_held, off_valid, off_moved};
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL idle_tick%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        n_cmp++;
        if (pulses != 0 || col_out !== 4'b1110) begin
            n_fail++;
            $display("FAIL idle_summary: got pulses=%0d col=%b want 0/1110", pulses, col_out);
        end
    endtask

    task automatic test_short_press();
        seek_col(0);
        for (int i = 0; i < 3; i++) begin
            pressed = (i < 2) ? 16'h0001 : 16'h0000;
            tick_step();
            obs = {col_out, key_valid, key_code, key_held, off_valid, off_moved};
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL short_tick%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        n_cmp++;
        if ({col_out, key_held, key_valid} !== {4'b1101, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL short_resume: got col=%b held=%b v=%b want 1101/0/0",
                     col_out, key_held, key_valid);
        end
    endtask

    task automatic test_press_hold();
        int pulses;
        pulses = 0;
        seek_col(2);
        pressed = 16'h0040;  // row 1, col 2
        for (int i = 0; i < 6; i++) begin
            tick_step();
            if (key_valid) pulses++;
            obs = {col_out, key_valid, key_code, key_held, off_valid, off_moved};
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL hold_tick%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        n_cmp++;
        if (pulses != 1 || {key_code, key_held, col_out} !== {4'd6, 1'b1, 4'b1011}) begin
            n_fail++;
            $display("FAIL hold_result: got pulses=%0d code=%0d held=%b col=%b want 1/6/1/1011",
                     pulses, key_code, key_held, col_out);
        end
    endtask

    task automatic test_bounce();
        int pulses;
        logic [15:0] seq [6];
        seq = '{16'h0000, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            pressed = seq[i];
            tick_step();
            if (key_valid) pulses++;
            obs = {col_out, key_valid, key_code, key_held, off_valid, off_moved};
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL bounce_tick%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        // Release confirmed on the last step: scanning resumes past column 2.
        n_cmp++;
        if (pulses != 0 || {key_held, key_code, col_out} !== {1'b0, 4'd6, 4'b0111}) begin
            n_fail++;
            $display("FAIL bounce_result: got pulses=%0d held=%b code=%0d col=%b want 0/0/6/0111",
                     pulses, key_held, key_code, col_out);
        end
    endtask

    task automatic test_multi_row();
        seek_col(1);
        pressed = 16'h2200;  // rows 2 and 3 on col 1
        for (int i = 0; i < 5; i++) begin
            tick_step();
            obs = {col_out, key_valid, key_code, key_held, off_valid, off_moved};
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL multi_tick%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        n_cmp++;
        if ({key_code, key_held} !== {4'd9, 1'b1}) begin
            n_fail++;
            $display("FAIL multi_code: got code=%0d held=%b want 9/1", key_code, key_held);
        end
    endtask

    task automatic test_reset_held();
        int pulses;
        int first_code;
        pulses = 0;
        first_code = -1;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({col_out, key_held, key_code, key_valid} !== {4'b1110, 1'b0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_held_async: got col=%b held=%b code=%h v=%b want 1110/0/0/0",
                     col_out, key_held, key_code, key_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            tick_step();
            if (key_valid) begin
                pulses++;
                if (first_code < 0) first_code = int'(key_code);
            end
            obs = {col_out, key_valid, key_code, key_held, off_valid, off_moved};
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL rst_held_tick%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        n_cmp++;
        if (pulses != 1 || first_code != 9) begin
            n_fail++;
            $display("FAIL rst_held_repress: got pulses=%0d code=%0d want 1/9", pulses, first_code);
        end
    endtask

    task automatic test_random();
        int sel;
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0) pressed = '0;
            else if (sel == 1) pressed = 16'(1) << $urandom_range(0, 15);
            else if (sel == 2) pressed = 16'($urandom) & 16'($urandom) & 16'($urandom);
            tick_step();
            obs = {col_out, key_valid, key_code, key_held, off_valid, off_moved};
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_tick%0d: got %h want %h pressed=%h",
                         i, obs, exp_vec(), pressed);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b0;
        pressed = '0;
        model_reset();
        #1;
        test_reset();
        test_idle_scan();
        test_short_press();
        test_press_hold();
        test_bounce();
        test_multi_row();
        test_reset_held();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
